coprocessor0_registers: RTL and testbench
=========================================

# coprocessor0_registers

Implements the MIPS coprocessor 0 register file and is the receiving end of the writeback-to-CP0 bus (`WBToCP0Data`). It holds BadVAddr, Count, Compare, Status, Cause and EPC. It performs `mtc0` writes, exception entry, and `eret` exit, and runs the Count/Compare timer. It also evaluates interrupt conditions. It sits beside the writeback stage: `mfc0` reads, the exception redirect target, and the interrupt request all come from here.

## Interface
- `EXCEPTION_CODE_ADEL`, default 5'h04, load/fetch address-error code; updates BadVAddr.
- `EXCEPTION_CODE_ADES`, default 5'h05, store address-error code; updates BadVAddr.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_to_cp0`  in  `WBToCP0Data`  register address/select, write enable, write data, `exception_valid`, `eret_flish`.
- `exception_code`  in  5  ExcCode; qualified by `exception_valid`.
- `exception_in_delay_slot`  in  1  faulting instruction is in a delay slot.
- `exception_pc`  in  32  PC of the faulting instruction.
- `exception_bad_address`  in  32  faulting virtual address, used for AdEL/AdES.
- `hardware_interrupt`  in  6  external interrupt lines, level-sensitive.
- `read_data`  out  32  value of the addressed register, combinational.
- `epc`  out  32  current EPC, used as the `eret` target.
- `status_exception_level`  out  1  Status.EXL.
- `interrupt_pending`  out  1  interrupt request toward writeback.

## Operation
- Decode (register, select) as follows:
  - (8,0) BadVAddr
  - (9,0) Count
  - (11,0) Compare
  - (12,0) Status
  - (13,0) Cause
  - (14,0) EPC
  - Any other address reads 0 and ignores writes.
- Status (`StatusData` layout):
  - BEV is a read-only constant 1.
  - IM[7:0], EXL and IE are writable.
  - All other bits read 0.
- Cause (`CauseData` layout):
  - IP[1:0] (software) is writable.
  - IP[7:2] is sampled every cycle: IP[7:2] = {`hardware_interrupt[5]` | TI, `hardware_interrupt[4:0]`}.
  - TI, BD and ExcCode are written only by hardware.
- EPC and Compare are fully writable. BadVAddr is read-only.
- Count: a 1-bit `tick` toggles every cycle, and Count increments when `tick`=1, i.e. every 2 cycles. Count wraps 32'hFFFF_FFFF→0.
- Timer:
  - TI sets the cycle after Count (post-update) equals Compare.
  - A write to Compare clears TI.
  - TI is otherwise sticky.
- Exception entry (`exception_valid`=1):
  - EXL←1 and ExcCode←`exception_code`.
  - If EXL was 0: BD←`exception_in_delay_slot`, and EPC←`exception_pc`−4 if in a delay slot, else `exception_pc`.
  - If EXL was already 1: EPC and BD are unchanged.
  - For AdEL/AdES: BadVAddr←`exception_bad_address`.
- `eret_flish`=1 without an exception: EXL←0.
- Priority in one cycle: exception > eret > mtc0 write.
  - A write is ignored when `exception_valid` or `eret_flish` is set.
  - An mtc0 write to Count overrides that cycle's increment.
  - An mtc0 write to Compare overrides that cycle's TI set.
- `interrupt_pending` = IE & ~EXL & |(Cause.IP & Status.IM), combinational from registered state.

## Timing
- Reset values (asynchronous):
  - Status = 32'h0040_0000
  - Cause = 0, EPC = 0, Count = 0, Compare = 0, BadVAddr = 0, `tick` = 0
  - Outputs: `read_data` reflects the addressed reset value, `epc` = 0, `status_exception_level` = 0, `interrupt_pending` = 0.
- Reads are zero-latency and return the pre-edge value. A write at edge N is visible at `read_data` from cycle N+1, with no bypass.
- Exception/eret effects are visible at `epc` and `status_exception_level` in the cycle after the request.
- Hardware interrupt lines reach `interrupt_pending` 1 cycle after they change (through the IP sample).
- Reset asserted mid-operation returns every register, including the timer, to its reset value immediately.

## Test plan
- Reset:
  - Stimulus: assert `reset_n`=0 mid-run.
  - Required: `read_data` at (12,0) = 32'h0040_0000; `epc`=0, `interrupt_pending`=0 during reset and the first cycle after.
- mtc0/mfc0:
  - Stimulus: write 32'hFFFF_FFFF to Status.
  - Required: read-back = 32'h0040_FF03.
  - Stimulus: write 32'h1234_5678 to EPC.
  - Required: read-back = 32'h1234_5678 next cycle.
- Exception in delay slot:
  - Stimulus: `exception_pc`=32'hBFC0_0104, BD=1, code 5'h04, bad address 32'h0000_0003.
  - Required: EPC=32'hBFC0_0100, Cause=32'h8000_0010, BadVAddr=32'h3, EXL=1.
  - Stimulus: a second exception while EXL=1.
  - Required: EPC is unchanged.
- Eret vs write:
  - Stimulus: `eret_flish` and an mtc0 write of EPC in the same cycle.
  - Required: EXL→0, EPC is not written.
- Timer:
  - Stimulus: Compare=10, Count=0, IE=1, IM[7]=1.
  - Required: TI and `interrupt_pending` are set ≈20 cycles later.
  - Stimulus: write Compare.
  - Required: `interrupt_pending` is cleared the next cycle.
  - Stimulus: Count=32'hFFFF_FFFF.
  - Required: Count wraps to 0.
- Hardware interrupt:
  - Stimulus: `hardware_interrupt`=6'b000001 with IM[2]=1, IE=1, EXL=0.
  - Required: `interrupt_pending`=1 after 1 cycle.
  - Stimulus: set EXL=1.
  - Required: `interrupt_pending`=0.

Source files
------------

// File: rtl/coprocessor0_registers.sv
// MIPS CP0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC.
// Handles mtc0 writes, exception entry, eret exit and interrupt evaluation.
package cp0_pkg;
  typedef struct packed {
    logic [4:0]  address;
    logic [2:0]  select;
    logic        write_enable;
    logic [31:0] write_data;
    logic        exception_valid;
    logic        eret_flish;
  } WBToCP0Data;
endpackage

module coprocessor0_registers
  import cp0_pkg::*;
#(
  parameter logic [4:0] EXCEPTION_CODE_ADEL = 5'h04,
  parameter logic [4:0] EXCEPTION_CODE_ADES = 5'h05
) (
  input  logic        clock,
  input  logic        reset_n,
  input  WBToCP0Data  wb_to_cp0,
  input  logic [4:0]  exception_code,
  input  logic        exception_in_delay_slot,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_bad_address,
  input  logic [5:0]  hardware_interrupt,
  output logic [31:0] read_data,
  output logic [31:0] epc,
  output logic        status_exception_level,
  output logic        interrupt_pending
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] bad_vaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [4:0]  cause_exc_code;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  hw_sampled;
  logic [7:0]  cause_ip;
  logic [31:0] status_word;
  logic [31:0] cause_word;

  logic sel_zero;
  logic exc;
  logic eret;
  logic wr_en;

  assign sel_zero = (wb_to_cp0.select == 3'd0);
  assign exc      = wb_to_cp0.exception_valid;
  assign eret     = wb_to_cp0.eret_flish & ~exc;
  assign wr_en    = wb_to_cp0.write_enable & ~wb_to_cp0.exception_valid & ~wb_to_cp0.eret_flish & sel_zero;

  // TI joins IP[7] directly so a Compare write drops the request on the next cycle.
  assign cause_ip    = {hw_sampled[5] | cause_ti, hw_sampled[4:0], cause_ip_sw};
  assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_word  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc_code, 2'b00};

  always_comb begin
    read_data = 32'd0;
    if (sel_zero) begin
      case (wb_to_cp0.address)
        REG_BADVADDR: read_data = bad_vaddr;
        REG_COUNT:    read_data = count;
        REG_COMPARE:  read_data = compare;
        REG_STATUS:   read_data = status_word;
        REG_CAUSE:    read_data = cause_word;
        REG_EPC:      read_data = epc;
        default:      read_data = 32'd0;
      endcase
    end
  end

  assign status_exception_level = status_exl;
  assign interrupt_pending      = status_ie & ~status_exl & |(cause_ip & status_im);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bad_vaddr      <= 32'd0;
      count          <= 32'd0;
      compare        <= 32'd0;
      tick           <= 1'b0;
      status_im      <= 8'd0;
      status_exl     <= 1'b0;
      status_ie      <= 1'b0;
      cause_bd       <= 1'b0;
      cause_ti       <= 1'b0;
      cause_exc_code <= 5'd0;
      cause_ip_sw    <= 2'd0;
      hw_sampled     <= 6'd0;
      epc            <= 32'd0;
    end else begin
      tick       <= ~tick;
      hw_sampled <= hardware_interrupt;

      if (wr_en && wb_to_cp0.address == REG_COUNT)
        count <= wb_to_cp0.write_data;
      else if (tick)
        count <= count + 32'd1;

      // A Compare write acknowledges the timer and wins over a same-cycle match.
      if (wr_en && wb_to_cp0.address == REG_COMPARE) begin
        compare  <= wb_to_cp0.write_data;
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end

      if (exc) begin
        status_exl     <= 1'b1;
        cause_exc_code <= exception_code;
        if (!status_exl) begin
          cause_bd <= exception_in_delay_slot;
          epc      <= exception_in_delay_slot ? exception_pc - 32'd4 : exception_pc;
        end
        if (exception_code == EXCEPTION_CODE_ADEL || exception_code == EXCEPTION_CODE_ADES)
          bad_vaddr <= exception_bad_address;
      end else if (eret) begin
        status_exl <= 1'b0;
      end else if (wr_en) begin
        case (wb_to_cp0.address)
          REG_STATUS: begin
            status_im  <= wb_to_cp0.write_data[15:8];
            status_exl <= wb_to_cp0.write_data[1];
            status_ie  <= wb_to_cp0.write_data[0];
          end
          REG_CAUSE: cause_ip_sw <= wb_to_cp0.write_data[9:8];
          REG_EPC:   epc         <= wb_to_cp0.write_data;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coprocessor0_registers.sv
// Directed bench for coprocessor0_registers with a queue-based scoreboard.
module tb_coprocessor0_registers;
  import cp0_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  WBToCP0Data  wb;
  logic [4:0]  exception_code;
  logic        exception_in_delay_slot;
  logic [31:0] exception_pc;
  logic [31:0] exception_bad_address;
  logic [5:0]  hardware_interrupt;
  logic [31:0] read_data;
  logic [31:0] epc;
  logic        status_exception_level;
  logic        interrupt_pending;

  coprocessor0_registers dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .wb_to_cp0              (wb),
    .exception_code         (exception_code),
    .exception_in_delay_slot(exception_in_delay_slot),
    .exception_pc           (exception_pc),
    .exception_bad_address  (exception_bad_address),
    .hardware_interrupt     (hardware_interrupt),
    .read_data              (read_data),
    .epc                    (epc),
    .status_exception_level (status_exception_level),
    .interrupt_pending      (interrupt_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_item_t it;
    it.tag = tag;
    it.val = v;
    sb.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wb.address = a;
    wb.select = 3'd0;
    wb.write_data = d;
    wb.write_enable = 1'b1;
    cyc();
    wb.write_enable = 1'b0;
  endtask

  task automatic mfc0(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    wb.address = a;
    wb.select = s;
    #1;
    d = read_data;
  endtask

  task automatic raise_exception(input logic [4:0] code, input logic ds,
                                 input logic [31:0] pc, input logic [31:0] bad);
    exception_code = code;
    exception_in_delay_slot = ds;
    exception_pc = pc;
    exception_bad_address = bad;
    wb.exception_valid = 1'b1;
    cyc();
    wb.exception_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int n;

    reset_n = 1'b0;
    wb = '0;
    exception_code = 5'd0;
    exception_in_delay_slot = 1'b0;
    exception_pc = 32'd0;
    exception_bad_address = 32'd0;
    hardware_interrupt = 6'd0;

    cyc();
    cyc();
    expect_val("reset_status", 32'h0040_0000);
    mfc0(5'd12, 3'd0, v);
    check(v);
    expect_val("reset_epc", 32'd0);
    check(epc);
    expect_val("reset_pending", 32'd0);
    check({31'd0, interrupt_pending});
    reset_n = 1'b1;
    cyc();
    expect_val("post_reset_epc", 32'd0);
    check(epc);
    expect_val("post_reset_pending", 32'd0);
    check({31'd0, interrupt_pending});

    // Park Compare far away so the reset-time match is acknowledged.
    mtc0(5'd11, 32'hFFFF_0000);
    expect_val("compare_readback", 32'hFFFF_0000);
    mfc0(5'd11, 3'd0, v);
    check(v);

    mtc0(5'd12, 32'hFFFF_FFFF);
    expect_val("status_mask", 32'h0040_FF03);
    mfc0(5'd12, 3'd0, v);
    check(v);
    mtc0(5'd12, 32'h0000_0000);

    mtc0(5'd14, 32'h1234_5678);
    expect_val("epc_readback", 32'h1234_5678);
    mfc0(5'd14, 3'd0, v);
    check(v);

    mtc0(5'd15, 32'hA5A5_A5A5);
    expect_val("unmapped_reg", 32'd0);
    mfc0(5'd15, 3'd0, v);
    check(v);
    expect_val("nonzero_select", 32'd0);
    mfc0(5'd12, 3'd1, v);
    check(v);

    raise_exception(5'h04, 1'b1, 32'hBFC0_0104, 32'h0000_0003);
    expect_val("exc_epc_ds", 32'hBFC0_0100);
    check(epc);
    expect_val("exc_exl", 32'd1);
    check({31'd0, status_exception_level});
    expect_val("exc_cause", 32'h8000_0010);
    mfc0(5'd13, 3'd0, v);
    check(v);
    expect_val("exc_badvaddr", 32'h0000_0003);
    mfc0(5'd8, 3'd0, v);
    check(v);

    raise_exception(5'h05, 1'b0, 32'h8000_0000, 32'h0000_0044);
    expect_val("nested_epc_kept", 32'hBFC0_0100);
    check(epc);
    expect_val("nested_cause", 32'h8000_0014);
    mfc0(5'd13, 3'd0, v);
    check(v);
    expect_val("nested_badvaddr", 32'h0000_0044);
    mfc0(5'd8, 3'd0, v);
    check(v);

    wb.eret_flish = 1'b1;
    mtc0(5'd14, 32'hDEAD_BEEF);
    wb.eret_flish = 1'b0;
    expect_val("eret_exl", 32'd0);
    check({31'd0, status_exception_level});
    expect_val("eret_epc_kept", 32'hBFC0_0100);
    check(epc);

    mtc0(5'd12, 32'h0000_0401);
    hardware_interrupt = 6'b000001;
    expect_val("hw_irq_not_yet", 32'd0);
    check({31'd0, interrupt_pending});
    cyc();
    expect_val("hw_irq_pending", 32'd1);
    check({31'd0, interrupt_pending});
    mtc0(5'd12, 32'h0000_0403);
    expect_val("hw_irq_masked_exl", 32'd0);
    check({31'd0, interrupt_pending});
    hardware_interrupt = 6'd0;
    mtc0(5'd12, 32'h0000_0000);

    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    n = 0;
    while (!interrupt_pending && n < 60) begin
      cyc();
      n++;
    end
    expect_val("timer_fire_window", 32'd1);
    check({31'd0, interrupt_pending && n >= 12 && n <= 30});
    expect_val("timer_ti_bit", 32'd1);
    mfc0(5'd13, 3'd0, v);
    check({31'd0, v[30]});

    mtc0(5'd11, 32'h0000_0100);
    expect_val("timer_cleared", 32'd0);
    check({31'd0, interrupt_pending});

    mtc0(5'd9, 32'hFFFF_FFFF);
    v = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      mfc0(5'd9, 3'd0, v);
      if (v != 32'hFFFF_FFFF) break;
      cyc();
    end
    expect_val("count_wrap", 32'd0);
    check(v);

    mtc0(5'd12, 32'h0000_FF01);
    mtc0(5'd14, 32'h0BAD_0000);
    reset_n = 1'b0;
    expect_val("midrun_status", 32'h0040_0000);
    mfc0(5'd12, 3'd0, v);
    check(v);
    expect_val("midrun_count", 32'd0);
    mfc0(5'd9, 3'd0, v);
    check(v);
    expect_val("midrun_epc", 32'd0);
    check(epc);
    expect_val("midrun_pending", 32'd0);
    check({31'd0, interrupt_pending});
    cyc();
    reset_n = 1'b1;
    cyc();
    expect_val("midrun_after_pending", 32'd0);
    check({31'd0, interrupt_pending});
    expect_val("midrun_after_epc", 32'd0);
    check(epc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
